prio_encoder_q: RTL

- Parametrised, registered successor to the 8-to-3 one-hot encoder.
- Accepts multi-hot request words and latches each request bit as pending.
- Emits pending bit indices one at a time, in priority order, over a valid/ready handshake.
- Used wherever several lab event sources (buttons, switches, timers) must be serialised into a single index stream.

---
 rtl/prio_encoder_q_if.sv | 14 +
 rtl/prio_encoder_q.sv | 54 +++++
 2 files changed

// File: rtl/prio_encoder_q_if.sv
// prio_encoder_q_if: request/grant bundle for prio_encoder_q
// slave is the encoder side, master is the producer/consumer side
interface prio_encoder_q_if #(parameter int N = 8, localparam int IDX_W = $clog2(N));
   logic [N-1:0]     req_in;
   logic             req_valid;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     pending;
   logic             busy;
   logic             overflow;
   modport master(output req_in, req_valid, out_ready, input out_idx, out_valid, pending, busy, overflow);
   modport slave(input req_in, req_valid, out_ready, output out_idx, out_valid, pending, busy, overflow);
endinterface

// File: rtl/prio_encoder_q.sv
// prio_encoder_q: latches multi-hot requests as pending and serialises their indices over valid/ready
// PRIO_ENCODER_RR_EN selects round-robin instead of lowest-index priority
module prio_encoder_q #(parameter int N = 8, localparam int IDX_W = $clog2(N)) (
   input logic clk,
   input logic rst_n,
   prio_encoder_q_if.slave bus
);
   logic [N-1:0]     pend, set, clr;
   logic [IDX_W-1:0] sel, idx_q;
   logic             vld_q, ovf_q, load;
   assign set  = bus.req_valid ? bus.req_in : '0;
   assign load = (|pend) & (~vld_q | bus.out_ready);
   assign clr  = load ? N'(1) << sel : '0;
`ifdef PRIO_ENCODER_RR_EN
   logic [IDX_W-1:0] ptr, k;
   // descending scan so the smallest offset from ptr is written last
   always_comb begin
      sel = '0;
      k = '0;
      for (int j = N - 1; j >= 0; j--) begin
         k = IDX_W'((int'(ptr) + j) % N);
         if (pend[k]) sel = k;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (load) ptr <= (sel == IDX_W'(N - 1)) ? '0 : sel + IDX_W'(1);
`else
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--)
         if (pend[i]) sel = IDX_W'(i);
   end
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pend  <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         pend  <= (pend & ~clr) | set;
         ovf_q <= |(set & pend & ~clr);
         if (load) begin
            idx_q <= sel;
            vld_q <= 1'b1;
         end else if (bus.out_ready) vld_q <= 1'b0;
      end
   assign bus.out_idx   = idx_q;
   assign bus.out_valid = vld_q;
   assign bus.pending   = pend;
   assign bus.busy      = vld_q | (|pend);
   assign bus.overflow  = ovf_q;
endmodule
